// File: rtl/ps2_kbd_ctrl.sv
// PS/2 Set-2 keyboard event decoder: parses E0/F0 prefixes from ps2_rx bytes
// and queues {ext, brk, code} events in a first-word-fall-through FIFO.
module ps2_kbd_ctrl #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 100000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  output logic                     rx_en,
  input  logic                     rx_done_tick,
  input  logic [7:0]               rx_data,
  output logic                     key_valid,
  output logic [7:0]               key_code,
  output logic                     key_ext,
  output logic                     key_brk,
  input  logic                     key_rd,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     ovf,
  input  logic                     ovf_clr,
  output logic                     proto_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK} state_t;

  state_t        state_q, state_d;
  logic          ext_q, ext_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          proto_err_q, proto_err_d;
  logic          ovf_q, ovf_d;

  logic          push, push_ext, push_brk;
  logic          accept, timeout, bad_byte;

  logic [9:0]    mem [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   count_q;
  logic          full, empty, pop, wr;
  logic [9:0]    head;

  assign accept   = rx_done_tick & en;
  assign bad_byte = (rx_data == 8'h00) || (rx_data == 8'hFF);
  // A tick in the same cycle as the deadline counts as the awaited byte.
  assign timeout  = (state_q != S_IDLE) && (tmo_q == TMO_LAST) && !accept;

  always_comb begin
    state_d     = state_q;
    ext_d       = ext_q;
    proto_err_d = 1'b0;
    push        = 1'b0;
    push_ext    = 1'b0;
    push_brk    = 1'b0;
    if (accept) begin
      unique case (state_q)
        S_IDLE: begin
          if (rx_data == 8'hE0) begin
            state_d = S_EXT;
            ext_d   = 1'b1;
          end else if (rx_data == 8'hF0) begin
            state_d = S_BRK;
            ext_d   = 1'b0;
          end else if (bad_byte) begin
            proto_err_d = 1'b1;
          end else begin
            push = 1'b1;
          end
        end
        S_EXT: begin
          if (rx_data == 8'hF0) begin
            state_d = S_BRK;
          end else if (rx_data == 8'hE0) begin
            state_d = S_EXT;
          end else if (bad_byte) begin
            state_d     = S_IDLE;
            ext_d       = 1'b0;
            proto_err_d = 1'b1;
          end else begin
            push     = 1'b1;
            push_ext = 1'b1;
            state_d  = S_IDLE;
            ext_d    = 1'b0;
          end
        end
        S_BRK: begin
          state_d = S_IDLE;
          ext_d   = 1'b0;
          if (bad_byte || rx_data == 8'hE0 || rx_data == 8'hF0) begin
            proto_err_d = 1'b1;
          end else begin
            push     = 1'b1;
            push_ext = ext_q;
            push_brk = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else if (timeout) begin
      state_d     = S_IDLE;
      ext_d       = 1'b0;
      proto_err_d = 1'b1;
    end
  end

  always_comb begin
    if (accept || timeout || state_q == S_IDLE) tmo_d = '0;
    else                                        tmo_d = tmo_q + 1'b1;
  end

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign pop   = key_rd & ~empty;
  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign wr    = push & (~full | pop);

  always_comb begin
    ovf_d = ovf_q;
    if (push && full && !pop) ovf_d = 1'b1;
    else if (ovf_clr)         ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ext_q       <= 1'b0;
      tmo_q       <= '0;
      proto_err_q <= 1'b0;
      ovf_q       <= 1'b0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      ext_q       <= ext_d;
      tmo_q       <= tmo_d;
      proto_err_q <= proto_err_d;
      ovf_q       <= ovf_d;
      if (wr)  wptr_q <= wptr_q + 1'b1;
      if (pop) rptr_q <= rptr_q + 1'b1;
      if (wr && !pop)      count_q <= count_q + 1'b1;
      else if (!wr && pop) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr && !reset) mem[wptr_q] <= {push_ext, push_brk, rx_data};
  end

  assign head       = mem[rptr_q];
  assign key_valid  = ~empty;
  assign key_code   = key_valid ? head[7:0] : 8'h00;
  assign key_brk    = key_valid & head[8];
  assign key_ext    = key_valid & head[9];
  assign fifo_count = count_q;
  assign ovf        = ovf_q;
  assign proto_err  = proto_err_q;
  assign rx_en      = en & ~full & ~reset;

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Bench for ps2_kbd_ctrl: directed sequences plus random byte streams, checked
// against a prefix-list / event-queue model of the keyboard protocol.
module tb_ps2_kbd_ctrl;
  localparam int DEPTH = 8;
  localparam int TMO   = 40;

  logic       clk = 1'b0;
  logic       reset, en, rx_done_tick, key_rd, ovf_clr;
  logic [7:0] rx_data;
  logic       rx_en, key_valid, key_ext, key_brk, ovf, proto_err;
  logic [7:0] key_code;
  logic [$clog2(DEPTH):0] fifo_count;

  int errors = 0;
  int checks = 0;

  // Reference model: pending prefix bytes, queued events, sticky overflow.
  logic [9:0]  mq[$];
  logic [7:0]  pfx[$];
  int          idle = 0;
  bit          m_ovf = 0;
  bit          m_err = 0;

  ps2_kbd_ctrl #(.DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .en(en), .rx_en(rx_en),
    .rx_done_tick(rx_done_tick), .rx_data(rx_data),
    .key_valid(key_valid), .key_code(key_code), .key_ext(key_ext),
    .key_brk(key_brk), .key_rd(key_rd), .fifo_count(fifo_count),
    .ovf(ovf), .ovf_clr(ovf_clr), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [9:0] exp_head;
    exp_head = (mq.size() > 0) ? mq[0] : 10'h000;
    chk("key_valid", 32'(key_valid), 32'(mq.size() > 0));
    chk("fifo_count", 32'(fifo_count), 32'(mq.size()));
    chk("head{ext,brk,code}", 32'({key_ext, key_brk, key_code}), 32'(exp_head));
    chk("ovf", 32'(ovf), 32'(m_ovf));
    chk("proto_err", 32'(proto_err), 32'(m_err));
    chk("rx_en", 32'(rx_en), 32'(en && !reset && mq.size() < DEPTH));
  endtask

  // Apply one cycle of inputs, advance the model, clock, then compare.
  task automatic step(input bit tick, input logic [7:0] b, input bit rd, input bit clr);
    bit push, pop, full_before, has_e0, has_f0;
    logic [9:0] ent;
    rx_done_tick = tick; rx_data = b; key_rd = rd; ovf_clr = clr;
    push = 0; ent = '0; m_err = 0;
    if (reset) begin
      mq.delete(); pfx.delete(); idle = 0; m_ovf = 0;
    end else begin
      if (tick && en) begin
        idle = 0;
        has_e0 = 0; has_f0 = 0;
        foreach (pfx[i]) begin
          if (pfx[i] == 8'hE0) has_e0 = 1;
          if (pfx[i] == 8'hF0) has_f0 = 1;
        end
        if (b == 8'h00 || b == 8'hFF) begin
          m_err = (pfx.size() > 0) || 1'b1;
          pfx.delete();
        end else if (b == 8'hE0) begin
          if (has_f0) begin m_err = 1; pfx.delete(); end
          else if (!has_e0) pfx.push_back(b);
        end else if (b == 8'hF0) begin
          if (has_f0) begin m_err = 1; pfx.delete(); end
          else pfx.push_back(b);
        end else begin
          push = 1; ent = {has_e0, has_f0, b}; pfx.delete();
        end
      end else if (pfx.size() > 0) begin
        idle++;
        if (idle == TMO) begin m_err = 1; pfx.delete(); idle = 0; end
      end
      full_before = (mq.size() == DEPTH);
      pop = rd && (mq.size() > 0);
      if (push && full_before && !pop) m_ovf = 1;
      else if (clr)                    m_ovf = 0;
      if (pop) void'(mq.pop_front());
      if (push && (!full_before || pop)) mq.push_back(ent);
    end
    @(posedge clk); #1;
    check_all();
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) step(0, 8'h00, 0, 0);
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < n; k++) step(0, 8'h00, 1, 0);
  endtask

  initial begin
    int first_err;
    logic [7:0] bb;
    reset = 1; en = 0; rx_done_tick = 0; rx_data = 0; key_rd = 0; ovf_clr = 0;
    idle_cycles(2);
    reset = 0; en = 1;
    idle_cycles(1);

    // Make/break of 1C
    step(1, 8'h1C, 0, 0);
    idle_cycles(1);
    step(1, 8'hF0, 0, 0);
    step(1, 8'h1C, 0, 0);
    drain(3);

    // Extended make/break of 75
    step(1, 8'hE0, 0, 0);
    step(1, 8'h75, 0, 0);
    step(1, 8'hE0, 0, 0);
    step(1, 8'hF0, 0, 0);
    step(1, 8'h75, 0, 0);
    drain(3);

    // F0 followed by silence: error exactly TMO cycles after the tick
    step(1, 8'hF0, 0, 0);
    first_err = -1;
    for (int k = 1; k <= TMO + 3; k++) begin
      step(0, 8'h00, 0, 0);
      if (proto_err && first_err < 0) first_err = k;
    end
    chk("timeout_latency", 32'(first_err), 32'(TMO));
    step(1, 8'h1C, 0, 0);
    drain(2);

    // Fill, forced overflow tick, drain, clear ovf
    for (int k = 1; k <= DEPTH; k++) step(1, 8'(k), 0, 0);
    step(1, 8'h09, 0, 0);
    drain(DEPTH + 1);
    step(0, 8'h00, 0, 1);

    // Full FIFO with simultaneous push and pop
    for (int k = 0; k < DEPTH; k++) step(1, 8'(8'h40 + k), 0, 0);
    step(1, 8'h2A, 1, 0);
    drain(DEPTH + 1);

    // Illegal sequences and ignored ticks while disabled
    step(1, 8'h00, 0, 0);
    step(1, 8'hE0, 0, 0);
    step(1, 8'hFF, 0, 0);
    step(1, 8'hF0, 0, 0);
    step(1, 8'hE0, 0, 0);
    en = 0;
    step(1, 8'h33, 0, 0);
    en = 1;
    idle_cycles(1);

    // Reset in the middle of an extended prefix
    step(1, 8'hE0, 0, 0);
    reset = 1;
    idle_cycles(2);
    reset = 0;
    step(1, 8'h75, 0, 0);
    drain(2);

    // Random streams biased toward prefixes and error codes
    for (int i = 0; i < 500; i++) begin
      case ($urandom_range(0, 9))
        0, 1:    bb = 8'hE0;
        2, 3:    bb = 8'hF0;
        4:       bb = ($urandom_range(0, 1) != 0) ? 8'h00 : 8'hFF;
        default: bb = 8'($urandom_range(1, 254));
      endcase
      en = ($urandom_range(0, 15) != 0);
      step($urandom_range(0, 1) != 0, bb, $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0);
      if ($urandom_range(0, 59) == 0) idle_cycles(TMO);
    end
    en = 1;
    drain(DEPTH + 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ps2_kbd_ctrl.md
# ps2_kbd_ctrl

Keyboard-side controller that sequences the `ps2_rx` byte receiver and turns its raw scan-code stream into decoded key events for the processor. It gates the receiver with `rx_en` and parses the Set-2 prefixes `E0` (extended) and `F0` (break). Completed events go into a small first-word-fall-through FIFO, which the processor drains with a one-cycle read strobe. It sits between `ps2_rx` and the processor's memory-mapped keyboard port.

## Interface
- `DEPTH`, 8: FIFO entries; power of 2, at least 2.
- `TIMEOUT`, 100000: maximum idle cycles allowed between a prefix and its following byte (1 ms at 100 MHz).
- `clk` in 1: system clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-high; one clock, synchronous reset only.
- `en` in 1: controller enable from the processor.
- `rx_en` out 1: enable to `ps2_rx`; equals `en & ~full & ~reset` (combinational).
- `rx_done_tick` in 1: one-cycle pulse from `ps2_rx`; byte valid on `rx_data`.
- `rx_data` in 8: received byte.
- `key_valid` out 1: FIFO non-empty.
- `key_code` out 8: head entry scan code.
- `key_ext` out 1: head entry was `E0`-prefixed.
- `key_brk` out 1: head entry is a release (`F0`-prefixed).
- `key_rd` in 1: pop the head entry; ignored when `key_valid` = 0.
- `fifo_count` out `$clog2(DEPTH)+1`: current occupancy.
- `ovf` out 1: sticky overflow flag.
- `ovf_clr` in 1: clears `ovf`; a set in the same cycle wins.
- `proto_err` out 1: one-cycle pulse on a dropped or illegal byte sequence.

## Operation
- Bytes are consumed only on cycles where `rx_done_tick` = 1. Ticks arriving while `en` = 0 are ignored, and the FSM holds its state.
- The FSM has 3 states: IDLE, EXT, BRK. It also holds a registered `ext_f`.
- IDLE:
  - `E0` → EXT, with `ext_f` = 1.
  - `F0` → BRK, with `ext_f` = 0.
  - `00` or `FF` (keyboard error/overrun codes) → discard and pulse `proto_err`.
  - Any other byte → push {ext=0, brk=0, code}.
- EXT:
  - `F0` → BRK, keeping `ext_f` = 1.
  - `E0` → stay in EXT and restart the timeout.
  - `00` or `FF` → IDLE, with `proto_err`.
  - Any other byte → push {1, 0, code}, then IDLE.
- BRK:
  - `E0`, `F0`, `00` or `FF` → IDLE, with `proto_err`; nothing is pushed.
  - Any other byte → push {`ext_f`, 1, code}, then IDLE.
- Timeout: a counter clears on every entry to EXT or BRK and on every accepted tick. If it reaches `TIMEOUT` while in EXT or BRK, the FSM goes to IDLE, clears `ext_f` and pulses `proto_err`.
- FIFO entries are 10 bits, {ext, brk, code}, with wrapping read and write pointers.
- Push and pop in the same cycle:
  - Both take effect and the count is unchanged.
  - When full, this is legal and is not an overflow.
- Push while full with no pop: the entry is dropped, `ovf` is set and the FIFO is unchanged.
- Pop while empty: no effect.
- Reset mid-sequence (for example after `E0` has been received) discards the partial prefix.

## Timing
- Reset values:
  - state IDLE, `ext_f` 0, pointers 0, `fifo_count` 0, timeout counter 0.
  - `key_valid` 0, `key_code` 00, `key_ext` 0, `key_brk` 0, `ovf` 0, `proto_err` 0.
  - `rx_en` 0 during reset.
- Push latency: the entry is written on the edge where `rx_done_tick` = 1. `key_valid` and the head fields update on the following cycle.
- Pop: on the edge where `key_rd` = 1, the head advances. The new head, or `key_valid` = 0, is visible the next cycle.
- `rx_en` drops in the same cycle `fifo_count` reaches `DEPTH`. It rises in the cycle after the pop that makes the FIFO non-full.
- `proto_err` is high for exactly one cycle, registered the cycle after the causing tick or timeout.
- The timeout fires exactly `TIMEOUT` cycles after the last accepted prefix tick.

## Test plan
- Make/break sequence `1C`, `F0 1C` → two entries: {0,0,1C} then {0,1,1C}. `key_valid` rises 1 cycle after the first tick.
- Extended sequence `E0 75`, `E0 F0 75` → entries {1,0,75} then {1,1,75}, with no `proto_err`.
- `F0`, then no byte for `TIMEOUT` cycles, then `1C`:
  - `proto_err` pulses once, exactly `TIMEOUT` cycles after the `F0` tick.
  - The following `1C` is pushed as {0,0,1C}.
- Fill with `DEPTH` bytes (`01`..`08`) while `key_rd` = 0:
  - `rx_en` drops when the FIFO is full.
  - A forced ninth tick with byte `09` sets `ovf`, and `fifo_count` stays 8.
  - Draining yields `01`..`08` in order.
  - `ovf_clr` then clears `ovf`.
- Full FIFO with a simultaneous tick (`2A`) and `key_rd`:
  - `fifo_count` stays 8 and `ovf` stays 0.
  - The tail entry is `2A`.
- Reset asserted after `E0`, then `75` sent → entry {0,0,75}, and all outputs match their reset values during reset.
